// File: rtl/sm_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - Transmitter FSM state encoding
//   - Register word offsets relative to BASE_ADDR
//   - STATUS register bit positions
package sm_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uartState_t;

  localparam logic [31:0] UART_REG_TXDATA = 32'd0;
  localparam logic [31:0] UART_REG_STATUS = 32'd1;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_PARITY    = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sm_uart_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears pointers and count)
//   push, pushData   write request and data; accepted when not full or when popping
//   pop, popData     read request; popData shows the head combinationally
//   full, empty      occupancy flags
//   count            number of stored entries, DEPTH_LOG2+1 bits
module sm_uart_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      pushData,
  input  logic                  pop,
  output logic [WIDTH-1:0]      popData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ptrOne = 1;
  localparam logic [DEPTH_LOG2:0]   cntOne = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic                  doPush;
  logic                  doPop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign popData = mem[rdPtr];
  assign doPop   = pop && !empty;
  // a full FIFO still takes a push when the head leaves on the same edge
  assign doPush  = push && (!full || doPop);

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + ptrOne;
      end
      if (doPop) begin
        rdPtr <= rdPtr + ptrOne;
      end
      if (doPush && !doPop) begin
        count <= count + cntOne;
      end else if (doPop && !doPush) begin
        count <= count - cntOne;
      end
    end
  end

endmodule

// File: rtl/sm_uart_mmio.sv
// Memory-mapped UART transmitter on the schoolMIPS data-memory port.
// TXDATA (BASE_ADDR) write pushes a byte; STATUS (BASE_ADDR+1) read reports
// {count[15:8], parity[3], ovf[2], full[1], busy[0]}; STATUS write clears ovf.
// Bytes are sent 8N1, LSB first; with SM_UART_PARITY_EN defined an even
// parity bit is inserted before the stop bit.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   dmAddr      CPU data word address
//   dmWe        CPU data write enable
//   dmWData     CPU write data (only [7:0] used)
//   dmRData     read data, 0 outside the UART window
//   sel         1 when dmAddr hits TXDATA or STATUS
//   uart_tx     serial line, idle high
module sm_uart_mmio
  import sm_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_4000,
  parameter logic [15:0] CLK_DIV         = 16'd434,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmAddr,
  input  logic        dmWe,
  input  logic [31:0] dmWData,
  output logic [31:0] dmRData,
  output logic        sel,
  output logic        uart_tx
);

  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;
`ifdef SM_UART_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic [31:0]      regOff;
  logic             selTx;
  logic             selStat;
  logic             pushReq;
  logic             ovfClr;
  logic             popReq;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       fifoRData;
  logic [CNT_W-1:0] fifoCount;
  logic             ovf;
  logic [31:0]      status;
  logic             unusedWData;

  uartState_t       state;
  logic [15:0]      baudCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic             bitEnd;
`ifdef SM_UART_PARITY_EN
  logic             parityBit;
`endif

  assign regOff  = dmAddr - BASE_ADDR;
  assign selTx   = (regOff == UART_REG_TXDATA);
  assign selStat = (regOff == UART_REG_STATUS);
  assign sel     = selTx || selStat;
  assign pushReq = dmWe && selTx;
  assign ovfClr  = dmWe && selStat;
  assign popReq  = (state == S_IDLE) && !fifoEmpty;
  assign bitEnd  = (baudCnt == 16'd0);

  assign unusedWData = ^dmWData[31:8];

  sm_uart_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pushReq),
    .pushData (dmWData[7:0]),
    .pop      (popReq),
    .popData  (fifoRData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Sticky overflow: only a push that the FIFO really drops sets it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovfClr) begin
      ovf <= 1'b0;
    end else if (pushReq && fifoFull && !popReq) begin
      ovf <= 1'b1;
    end
  end

  always_comb begin
    status                           = '0;
    status[STAT_COUNT_LSB +: CNT_W]  = fifoCount;
    status[STAT_PARITY]              = PARITY_EN;
    status[STAT_OVF]                 = ovf;
    status[STAT_FULL]                = fifoFull;
    status[STAT_BUSY]                = !fifoEmpty || (state != S_IDLE);
    dmRData                          = selStat ? status : 32'd0;
  end

  // Every non-idle state holds uart_tx for CLK_DIV cycles; the baud counter
  // runs CLK_DIV-1 down to 0 and the state advances on the 0 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baudCnt  <= 16'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'd0;
      uart_tx  <= 1'b1;
`ifdef SM_UART_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE) begin
        baudCnt <= bitEnd ? (CLK_DIV - 16'd1) : (baudCnt - 16'd1);
      end
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (!fifoEmpty) begin
            shiftReg <= fifoRData;
            baudCnt  <= CLK_DIV - 16'd1;
            uart_tx  <= 1'b0;
            state    <= S_START;
`ifdef SM_UART_PARITY_EN
            parityBit <= ^fifoRData;
`endif
          end
        end
        S_START: begin
          if (bitEnd) begin
            state    <= S_DATA;
            bitIdx   <= 3'd0;
            uart_tx  <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[7:1]};
          end
        end
        S_DATA: begin
          if (bitEnd) begin
            if (bitIdx == 3'd7) begin
`ifdef SM_UART_PARITY_EN
              state   <= S_PARITY;
              uart_tx <= parityBit;
`else
              state   <= S_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              uart_tx  <= shiftReg[0];
              shiftReg <= {1'b0, shiftReg[7:1]};
            end
          end
        end
`ifdef SM_UART_PARITY_EN
        S_PARITY: begin
          if (bitEnd) begin
            state   <= S_STOP;
            uart_tx <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bitEnd) begin
            state   <= S_IDLE;
            baudCnt <= 16'd0;
          end
        end
        default: begin
          state   <= S_IDLE;
          baudCnt <= 16'd0;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
